sd_port_arbiter: RTL and testbench

//  Multi-client front end for the SD SPI engines (sd_init/sd_write/sd_read).

---
 rtl/sd_port_arbiter.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_sd_port_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_port_arbiter.sv
// ---------------------------------------------------------------------------
// sd_port_arbiter
//
// Multi-client front end for the SD SPI engines (sd_init / sd_write / sd_read).
// NUM_CH block clients are served round-robin, one command at a time. The
// arbiter owns the SPI cs_n/mosi mux, inserts GAP_CYC idle cycles between
// commands (cs_n=1, mosi=1) and runs a busy watchdog on the active engine.
//
// Ports
//   sys_clk, sys_rst          clock, synchronous active-high reset
//   init_end/init_cs_n/mosi   sd_init status and SPI lines
//   ch_req/we/addr/wr_data    per-channel request bundle (packed per channel)
//   ch_gnt/done/err           one-hot grant, completion and failure pulses
//   ch_wr_req/ch_rd_data_en   engine handshakes routed to the granted channel
//   rd_data                   read data broadcast to every channel
//   eng_*                     start strobes, address/data and status to/from
//                             sd_write / sd_read
//   wr_*/rd_* cs_n, mosi      engine SPI lines
//   sd_cs_n, sd_mosi          SPI lines to the card
// ---------------------------------------------------------------------------
module sd_port_arbiter #(
    parameter int NUM_CH      = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 16,
    parameter int GAP_CYC     = 8,
    parameter int TIMEOUT_CYC = 1 << 20
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic                     init_end,
    input  logic                     init_cs_n,
    input  logic                     init_mosi,
    input  logic [NUM_CH-1:0]        ch_req,
    input  logic [NUM_CH-1:0]        ch_we,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    input  logic [NUM_CH*DATA_W-1:0] ch_wr_data,
    output logic [NUM_CH-1:0]        ch_gnt,
    output logic [NUM_CH-1:0]        ch_done,
    output logic [NUM_CH-1:0]        ch_err,
    output logic [NUM_CH-1:0]        ch_wr_req,
    output logic [NUM_CH-1:0]        ch_rd_data_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     eng_wr_en,
    output logic                     eng_rd_en,
    output logic [ADDR_W-1:0]        eng_addr,
    output logic [DATA_W-1:0]        eng_wr_data,
    input  logic                     eng_wr_busy,
    input  logic                     eng_rd_busy,
    input  logic                     eng_wr_req,
    input  logic                     eng_rd_data_en,
    input  logic [DATA_W-1:0]        eng_rd_data,
    input  logic                     wr_cs_n,
    input  logic                     wr_mosi,
    input  logic                     rd_cs_n,
    input  logic                     rd_mosi,
    output logic                     sd_cs_n,
    output logic                     sd_mosi
);

    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    // One counter serves the busy-wait window, the watchdog and the gap.
    localparam int CNT_W = $clog2(TIMEOUT_CYC + GAP_CYC + 4) + 1;
    localparam int BUSY_WAIT_CYC = 4;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_ACTIVE,
        S_DRAIN,
        S_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NUM_CH-1:0]  gnt_q, gnt_d;
    logic [PTR_W-1:0]   gnt_idx_q, gnt_idx_d;
    logic               op_q, op_d;          // 1 = write, 0 = read
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_CH-1:0]  done_q, done_d;
    logic [NUM_CH-1:0]  err_q, err_d;
    logic               wr_en_q, wr_en_d;
    logic               rd_en_q, rd_en_d;

    logic               arb_found;
    logic [PTR_W-1:0]   arb_idx;
    logic [PTR_W-1:0]   cand;
    logic               busy_sel;
    logic               eng_phase;

    // base + ofs modulo NUM_CH, with ofs < NUM_CH
    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] base,
                                                  input int ofs);
        int sum;
        sum = int'(base) + ofs;
        if (sum >= NUM_CH) sum = sum - NUM_CH;
        return PTR_W'(sum);
    endfunction

    // Round-robin search: first requester at or after rr_ptr, wrapping.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = wrap_inc(rr_ptr_q, i);
            if (!arb_found && ch_req[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    assign busy_sel  = op_q ? eng_wr_busy : eng_rd_busy;
    assign eng_phase = (state_q == S_WAIT_BUSY) || (state_q == S_ACTIVE);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= S_INIT;
            rr_ptr_q  <= '0;
            gnt_q     <= '0;
            gnt_idx_q <= '0;
            op_q      <= 1'b0;
            addr_q    <= '0;
            cnt_q     <= '0;
            done_q    <= '0;
            err_q     <= '0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            gnt_q     <= gnt_d;
            gnt_idx_q <= gnt_idx_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic. Every command ends through a "release": the grant
    // drops in the same cycle that done (and possibly err) pulses, and the
    // round-robin pointer moves past the channel just served.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        gnt_d     = gnt_q;
        gnt_idx_d = gnt_idx_q;
        op_d      = op_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        done_d    = '0;
        err_d     = '0;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;

        case (state_q)
            S_INIT: begin
                if (init_end) state_d = S_IDLE;
            end

            S_IDLE: begin
                if (arb_found) begin
                    state_d        = S_ISSUE;
                    gnt_d          = '0;
                    gnt_d[arb_idx] = 1'b1;
                    gnt_idx_d      = arb_idx;
                    op_d           = ch_we[arb_idx];
                    addr_d         = ch_addr[int'(arb_idx)*ADDR_W +: ADDR_W];
                    // Start strobe is registered so it is high for exactly
                    // the ISSUE cycle.
                    wr_en_d        = ch_we[arb_idx];
                    rd_en_d        = !ch_we[arb_idx];
                end
            end

            S_ISSUE: begin
                state_d = S_WAIT_BUSY;
                cnt_d   = '0;
            end

            S_WAIT_BUSY: begin
                if (busy_sel) begin
                    state_d = S_ACTIVE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(BUSY_WAIT_CYC - 1)) begin
                    // Engine never acknowledged the start strobe.
                    state_d  = S_GAP;
                    cnt_d    = '0;
                    done_d   = gnt_q;
                    err_d    = gnt_q;
                    gnt_d    = '0;
                    rr_ptr_d = wrap_inc(gnt_idx_q, 1);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_ACTIVE: begin
                if (!busy_sel) begin
                    state_d  = S_GAP;
                    cnt_d    = '0;
                    done_d   = gnt_q;
                    gnt_d    = '0;
                    rr_ptr_d = wrap_inc(gnt_idx_q, 1);
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    // Watchdog: fail the client now, then wait for the
                    // engine to let go before touching the bus again.
                    state_d  = S_DRAIN;
                    done_d   = gnt_q;
                    err_d    = gnt_q;
                    gnt_d    = '0;
                    rr_ptr_d = wrap_inc(gnt_idx_q, 1);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_DRAIN: begin
                if (!eng_wr_busy && !eng_rd_busy) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end
            end

            S_GAP: begin
                if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: state_d = S_INIT;
        endcase

        // Card lost init: abort whatever is in flight and re-enter INIT.
        if (state_q != S_INIT && !init_end) begin
            state_d = S_INIT;
            wr_en_d = 1'b0;
            rd_en_d = 1'b0;
            gnt_d   = '0;
            cnt_d   = '0;
            done_d  = '0;
            err_d   = '0;
            if (|gnt_q) begin
                done_d   = gnt_q;
                err_d    = gnt_q;
                rr_ptr_d = wrap_inc(gnt_idx_q, 1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign ch_gnt      = gnt_q;
    assign ch_done     = done_q;
    assign ch_err      = err_q;
    assign eng_wr_en   = wr_en_q;
    assign eng_rd_en   = rd_en_q;
    assign eng_addr    = addr_q;
    assign eng_wr_data = ch_wr_data[int'(gnt_idx_q)*DATA_W +: DATA_W];
    assign rd_data     = eng_rd_data;

    // Engine handshakes reach only the granted channel, and only while the
    // engine owns the bus for a command of the matching direction.
    assign ch_wr_req     = (eng_phase && op_q && eng_wr_req) ? gnt_q : '0;
    assign ch_rd_data_en = (eng_phase && !op_q && eng_rd_data_en) ? gnt_q : '0;

    // SPI line mux. Reset forces the idle level directly so the card sees a
    // deselected bus even though the state register reads INIT.
    always_comb begin
        sd_cs_n = 1'b1;
        sd_mosi = 1'b1;
        if (!sys_rst) begin
            if (state_q == S_INIT) begin
                sd_cs_n = init_cs_n;
                sd_mosi = init_mosi;
            end else if (eng_phase) begin
                sd_cs_n = op_q ? wr_cs_n : rd_cs_n;
                sd_mosi = op_q ? wr_mosi : rd_mosi;
            end
        end
    end

endmodule

// File: tb/tb_sd_port_arbiter.sv
// Directed bench for sd_port_arbiter. Two instances share all inputs: u_dut
// uses a long watchdog so long read bursts complete normally; u_wdt uses
// TIMEOUT_CYC=64 and is only checked in the watchdog scenario (after a reset
// that re-aligns both).
module tb_sd_port_arbiter;

    localparam int NUM_CH = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 16;

    logic sys_clk, sys_rst;
    logic init_end, init_cs_n, init_mosi;
    logic [NUM_CH-1:0] ch_req, ch_we;
    logic [NUM_CH*ADDR_W-1:0] ch_addr;
    logic [NUM_CH*DATA_W-1:0] ch_wr_data;
    logic [NUM_CH-1:0] ch_gnt, ch_done, ch_err, ch_wr_req, ch_rd_data_en;
    logic [DATA_W-1:0] rd_data, eng_wr_data, eng_rd_data;
    logic eng_wr_en, eng_rd_en;
    logic [ADDR_W-1:0] eng_addr;
    logic eng_wr_busy, eng_rd_busy, eng_wr_req, eng_rd_data_en;
    logic wr_cs_n, wr_mosi, rd_cs_n, rd_mosi, sd_cs_n, sd_mosi;

    logic [NUM_CH-1:0] w_gnt, w_done, w_err, w_wr_req, w_rd_de;
    logic [DATA_W-1:0] w_rd_data, w_eng_wr_data;
    logic w_eng_wr_en, w_eng_rd_en, w_cs_n, w_mosi;
    logic [ADDR_W-1:0] w_eng_addr;

    int checks = 0;
    int errors = 0;

    sd_port_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                      .GAP_CYC(8), .TIMEOUT_CYC(2048)) u_dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .init_end(init_end),
        .init_cs_n(init_cs_n), .init_mosi(init_mosi),
        .ch_req(ch_req), .ch_we(ch_we), .ch_addr(ch_addr), .ch_wr_data(ch_wr_data),
        .ch_gnt(ch_gnt), .ch_done(ch_done), .ch_err(ch_err),
        .ch_wr_req(ch_wr_req), .ch_rd_data_en(ch_rd_data_en), .rd_data(rd_data),
        .eng_wr_en(eng_wr_en), .eng_rd_en(eng_rd_en), .eng_addr(eng_addr),
        .eng_wr_data(eng_wr_data), .eng_wr_busy(eng_wr_busy), .eng_rd_busy(eng_rd_busy),
        .eng_wr_req(eng_wr_req), .eng_rd_data_en(eng_rd_data_en), .eng_rd_data(eng_rd_data),
        .wr_cs_n(wr_cs_n), .wr_mosi(wr_mosi), .rd_cs_n(rd_cs_n), .rd_mosi(rd_mosi),
        .sd_cs_n(sd_cs_n), .sd_mosi(sd_mosi)
    );

    sd_port_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                      .GAP_CYC(8), .TIMEOUT_CYC(64)) u_wdt (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .init_end(init_end),
        .init_cs_n(init_cs_n), .init_mosi(init_mosi),
        .ch_req(ch_req), .ch_we(ch_we), .ch_addr(ch_addr), .ch_wr_data(ch_wr_data),
        .ch_gnt(w_gnt), .ch_done(w_done), .ch_err(w_err),
        .ch_wr_req(w_wr_req), .ch_rd_data_en(w_rd_de), .rd_data(w_rd_data),
        .eng_wr_en(w_eng_wr_en), .eng_rd_en(w_eng_rd_en), .eng_addr(w_eng_addr),
        .eng_wr_data(w_eng_wr_data), .eng_wr_busy(eng_wr_busy), .eng_rd_busy(eng_rd_busy),
        .eng_wr_req(eng_wr_req), .eng_rd_data_en(eng_rd_data_en), .eng_rd_data(eng_rd_data),
        .wr_cs_n(wr_cs_n), .wr_mosi(wr_mosi), .rd_cs_n(rd_cs_n), .rd_mosi(rd_mosi),
        .sd_cs_n(w_cs_n), .sd_mosi(w_mosi)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Shortest run of cs_n=1 between two chip-select-low periods.
    logic mon_en;
    int   run_len, min_run;
    bit   seen_low;
    always @(negedge sys_clk) begin
        if (!mon_en) begin
            run_len  = 0;
            min_run  = 9999;
            seen_low = 0;
        end else if (sd_cs_n) begin
            run_len++;
        end else begin
            if (seen_low && run_len > 0 && run_len < min_run) min_run = run_len;
            run_len  = 0;
            seen_low = 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic wait_en(output bit got);
        got = 0;
        for (int n = 0; n < 60 && !got; n++) begin
            if (eng_wr_en || eng_rd_en) got = 1;
            else tick();
        end
    endtask

    // Play the selected engine for one normal command of len busy cycles.
    task automatic serve(input int exp_ch, input bit we, input int len);
        bit got;
        wait_en(got);
        chk("serve_en_seen", got, 1);
        chk("serve_gnt", ch_gnt, 4'b1 << exp_ch);
        chk("serve_en_kind", {eng_wr_en, eng_rd_en}, we ? 2'b10 : 2'b01);
        if (we) begin eng_wr_busy = 1; wr_cs_n = 0; end
        else    begin eng_rd_busy = 1; rd_cs_n = 0; end
        tick();                     // WAIT_BUSY
        tick();                     // ACTIVE
        repeat (len) tick();
        eng_wr_busy = 0; wr_cs_n = 1;
        eng_rd_busy = 0; rd_cs_n = 1;
        tick();
        chk("serve_done", ch_done, 4'b1 << exp_ch);
        chk("serve_err", ch_err, 0);
        chk("serve_gnt_clr", ch_gnt, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got stuck want finish");
        $fatal(1);
    end

    initial begin
        bit got;
        int n, cnt1;
        logic [NUM_CH-1:0] oth;

        mon_en = 0;
        sys_rst = 1; init_end = 0; init_cs_n = 0; init_mosi = 0;
        ch_req = 4'b1111; ch_we = '0; ch_addr = '0; ch_wr_data = '0;
        eng_wr_busy = 0; eng_rd_busy = 0; eng_wr_req = 0; eng_rd_data_en = 0;
        eng_rd_data = '0;
        wr_cs_n = 1; wr_mosi = 1; rd_cs_n = 1; rd_mosi = 1;

        // ---- 1: reset and INIT ----
        #1;
        chk("rst_cs_n", sd_cs_n, 1);
        chk("rst_mosi", sd_mosi, 1);
        tick(); tick(); tick();
        chk("rst_gnt", ch_gnt, 0);
        chk("rst_done_err", {ch_done, ch_err}, 0);
        chk("rst_en", {eng_wr_en, eng_rd_en}, 0);
        chk("rst_addr", eng_addr, 0);
        sys_rst = 0;
        tick();
        chk("init_cs_follow", sd_cs_n, 0);
        init_mosi = 1; init_cs_n = 1; #1;
        chk("init_mosi_follow", sd_mosi, 1);
        chk("init_cs_follow_hi", sd_cs_n, 1);
        repeat (5) tick();
        chk("init_no_gnt", ch_gnt, 0);

        // ---- 2: round-robin with all channels requesting ----
        mon_en = 1;
        init_end = 1;
        serve(0, 0, 3);
        serve(1, 0, 3);
        serve(2, 0, 3);
        serve(3, 0, 3);
        serve(0, 0, 3);
        ch_req = 0;
        // last ACTIVE cycle + GAP(8) + IDLE + ISSUE all show cs_n=1
        chk("rr_min_gap", min_run, 11);
        mon_en = 0;

        // ---- 3: write path on ch2 ----
        ch_addr[2*ADDR_W +: ADDR_W] = 32'h0000_1000;
        ch_wr_data[2*DATA_W +: DATA_W] = 16'hBEEF;
        ch_we = 4'b0100; ch_req = 4'b0100;
        wait_en(got);
        chk("wr_en_seen", got, 1);
        chk("wr_en_kind", {eng_wr_en, eng_rd_en}, 2'b10);
        chk("wr_addr", eng_addr, 32'h0000_1000);
        chk("wr_data", eng_wr_data, 16'hBEEF);
        chk("wr_gnt", ch_gnt, 4'b0100);
        ch_req = 0; eng_wr_busy = 1; wr_cs_n = 0;
        tick();
        chk("wr_en_one_cycle", eng_wr_en, 0);
        eng_wr_req = 1; #1;
        chk("wr_req_route_wb", ch_wr_req, 4'b0100);
        eng_wr_req = 0; #1;
        chk("wr_req_low", ch_wr_req, 0);
        tick();
        eng_wr_req = 1; #1;
        chk("wr_req_route_act", ch_wr_req, 4'b0100);
        chk("wr_no_rd_route", ch_rd_data_en, 0);
        eng_wr_req = 0;
        repeat (3) tick();
        eng_wr_busy = 0; wr_cs_n = 1;
        tick();
        chk("wr_done", ch_done, 4'b0100);
        chk("wr_err", ch_err, 0);

        // ---- 4: read path on ch1, 256 data pulses ----
        ch_we = 0; ch_req = 4'b0010;
        wait_en(got);
        chk("rd_en_seen", got, 1);
        chk("rd_en_kind", {eng_wr_en, eng_rd_en}, 2'b01);
        ch_req = 0; eng_rd_busy = 1; rd_cs_n = 0;
        tick(); tick();
        cnt1 = 0; oth = '0;
        for (int i = 0; i < 256; i++) begin
            eng_rd_data_en = 1; eng_rd_data = 16'(i); #1;
            cnt1 += int'(ch_rd_data_en[1]);
            oth |= ch_rd_data_en & 4'b1101;
            tick();
            eng_rd_data_en = 0; #1;
            cnt1 += int'(ch_rd_data_en[1]);
            tick();
        end
        chk("rd_pulse_count", cnt1, 256);
        chk("rd_other_bits", oth, 0);
        chk("rd_data_bcast", rd_data, 16'd255);
        eng_rd_busy = 0; rd_cs_n = 1;
        tick();
        chk("rd_done", ch_done, 4'b0010);
        chk("rd_err", ch_err, 0);

        // ---- engine never raises busy: fail after 4 WAIT_BUSY cycles ----
        ch_we = 4'b1000; ch_req = 4'b1000;
        wait_en(got);
        chk("nb_en_seen", got, 1);
        ch_req = 0;
        repeat (4) tick();
        chk("nb_not_yet", ch_done, 0);
        tick();
        chk("nb_done", ch_done, 4'b1000);
        chk("nb_err", ch_err, 4'b1000);
        chk("nb_gnt_clr", ch_gnt, 0);
        repeat (12) tick();

        // ---- 6a: init_end drop mid-ACTIVE ----
        ch_we = 0; ch_req = 4'b1000;
        wait_en(got);
        chk("ab_en_seen", got, 1);
        ch_req = 0; eng_rd_busy = 1; rd_cs_n = 0;
        tick(); tick(); repeat (3) tick();
        init_cs_n = 0; init_mosi = 0; init_end = 0;
        tick();
        chk("ab_done", ch_done, 4'b1000);
        chk("ab_err", ch_err, 4'b1000);
        chk("ab_gnt_clr", ch_gnt, 0);
        chk("ab_in_init", {sd_cs_n, sd_mosi}, 2'b00);
        eng_rd_busy = 0; rd_cs_n = 1; ch_req = 4'b1111;
        repeat (5) tick();
        chk("ab_hold_no_gnt", ch_gnt, 0);
        ch_req = 0; init_cs_n = 1; init_mosi = 1; init_end = 1;

        // ---- 5: watchdog (u_wdt, TIMEOUT_CYC=64) ----
        sys_rst = 1; tick(); tick();
        sys_rst = 0; tick(); tick();
        ch_addr[0 +: ADDR_W] = 32'h0000_2222;
        ch_wr_data[0 +: DATA_W] = 16'h1357;
        ch_we = 4'b0001; ch_req = 4'b0001;
        wait_en(got);
        chk("wd_en_seen", w_eng_wr_en, 1);
        ch_req = 0; eng_wr_busy = 1; wr_cs_n = 0;
        tick(); tick();
        n = 0;
        while (!w_done[0] && n < 200) begin tick(); n++; end
        chk("wd_cycles", n, 64);
        chk("wd_err", w_err, 4'b0001);
        chk("wd_gnt_clr", w_gnt, 0);
        chk("wd_addr", w_eng_addr, 32'h0000_2222);
        chk("wd_wdata", w_eng_wr_data, 16'h1357);
        chk("wd_main_active", ch_gnt, 4'b0001);
        repeat (5) tick();
        eng_rd_data = 16'h5A5A; #1;
        chk("wd_drain_cs", w_cs_n, 1);
        chk("wd_main_cs", sd_cs_n, 0);
        chk("wd_drain_quiet", {w_done, w_wr_req, w_rd_de, w_mosi}, 13'h001);
        chk("wd_rd_bcast", w_rd_data, 16'h5A5A);
        eng_wr_busy = 0; wr_cs_n = 1;
        ch_we = 0; ch_req = 4'b0010;
        n = 0;
        while (!w_eng_rd_en && n < 40) begin tick(); n++; end
        chk("wd_gap_to_issue", n, 10);
        ch_req = 0;
        serve(1, 0, 2);

        // ---- 6b: sys_rst mid-op ----
        ch_we = 4'b0100; ch_req = 4'b0100;
        wait_en(got);
        chk("sr_en_seen", got, 1);
        ch_req = 0; eng_wr_busy = 1; wr_cs_n = 0; init_cs_n = 0; init_mosi = 0;
        tick(); tick();
        sys_rst = 1;
        tick();
        chk("sr_gnt", ch_gnt, 0);
        chk("sr_done_err", {ch_done, ch_err}, 0);
        chk("sr_en", {eng_wr_en, eng_rd_en}, 0);
        chk("sr_addr", eng_addr, 0);
        chk("sr_lines", {sd_cs_n, sd_mosi}, 2'b11);
        sys_rst = 0; eng_wr_busy = 0; wr_cs_n = 1; init_cs_n = 1; init_mosi = 1;
        ch_we = 0; ch_req = 4'b1111;
        serve(0, 0, 2);     // rr pointer back at 0
        ch_req = 0;
        repeat (12) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
